rv32_fetch_unit: RTL and testbench

RV32_FETCH_UNIT -- requirements
Module: rv32_fetch_unit

---
 rtl/rv32_fetch_unit_if.sv | 14 +
 rtl/rv32_fetch_unit.sv | 85 ++++++++
 tb/tb_rv32_fetch_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_fetch_unit_if.sv
// rv32_fetch_unit_if: instruction-memory request/response bus between the fetch unit and imem
// Ports (master = fetch unit, slave = memory):
//   imem_req/imem_addr          request valid and word-aligned fetch address (master -> slave)
//   imem_gnt                    request accepted this cycle (slave -> master)
//   imem_rvalid/imem_rdata      in-order read response (slave -> master)
interface rv32_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit: RV32 instruction fetch with credit-based prefetch buffer and redirect flush
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   imem                        instruction-memory bus (master side)
//   redirect_i/redirect_pc_i    taken branch/jump: flush and refetch from new pc
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i   buffer head handshake to decode
//   fifo_level_o                occupied buffer entries
module rv32_fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                            clk,
  input  logic                            rstn,
  rv32_fetch_unit_if.master               imem,
  input  logic                            redirect_i,
  input  logic [31:0]                     redirect_pc_i,
  output logic                            instr_valid_o,
  output logic [31:0]                     instr_o,
  output logic [31:0]                     instr_pc_o,
  input  logic                            instr_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o
);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTST+1);
  typedef enum logic {FETCH, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc, resp_pc, target;
  logic [OW-1:0] outst, discard, outst_left;
  logic [LW-1:0] level;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [63:0] mem [FIFO_DEPTH];
  logic accept, rv, push, pop;
  // responses with nothing outstanding (e.g. left over from before reset) are ignored
  assign rv = imem.imem_rvalid && outst != '0;
  assign outst_left = outst - OW'(rv);
  assign target = redirect_pc_i & 32'hFFFF_FFFC;
  // credit: every outstanding request has a reserved buffer slot, so pushes never overflow
  assign imem.imem_req = state == FETCH && !redirect_i && 32'(outst) < MAX_OUTST &&
                         32'(outst) + 32'(level) < FIFO_DEPTH;
  assign imem.imem_addr = fetch_pc;
  assign accept = imem.imem_req && imem.imem_gnt;
  assign push = state == FETCH && rv && !redirect_i;
  assign pop = instr_valid_o && instr_ready_i && !redirect_i;
  assign instr_valid_o = level != '0;
  assign {instr_pc_o, instr_o} = mem[rd_ptr];
  assign fifo_level_o = level;
  always_comb begin
    state_n = state;
    if (redirect_i) state_n = outst_left == '0 ? FETCH : DRAIN;
    else if (state == DRAIN && rv && discard == OW'(1)) state_n = FETCH;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= FETCH;
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outst <= '0;
      discard <= '0;
      level <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_n;
      outst <= outst + OW'(accept) - OW'(rv);
      if (redirect_i) begin
        fetch_pc <= target;
        resp_pc <= target;
        discard <= outst_left;
        level <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (state == DRAIN && rv) discard <= discard - OW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        level <= level + LW'(push) - LW'(pop);
      end
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {resp_pc, imem.imem_rdata};
endmodule

// File: tb/tb_rv32_fetch_unit.sv
// tb_rv32_fetch_unit: directed and randomized checks of rv32_fetch_unit against an in-order imem model
module tb_rv32_fetch_unit;
  logic clk = 0, rstn = 1;
  logic redirect = 0, ready = 0, gnt = 0, rsp_en = 1, inj = 0;
  logic [31:0] redirect_pc = 0;
  logic m_rvalid = 0;
  logic [31:0] m_rdata = 0;
  logic instr_valid;
  logic [31:0] instr, instr_pc, exp_pc;
  logic [2:0] level;
  int checks = 0, failures = 0, n_acc = 0, pops = 0;
  logic [31:0] q[$];
  rv32_fetch_unit_if bus();
  assign bus.imem_gnt = gnt;
  assign bus.imem_rvalid = m_rvalid | inj;
  assign bus.imem_rdata = inj ? 32'hDEAD_BEEF : m_rdata;
  rv32_fetch_unit dut (
    .clk(clk), .rstn(rstn), .imem(bus),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(ready), .fifo_level_o(level)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      q.delete();
      m_rvalid <= 0;
      m_rdata <= 0;
      n_acc <= 0;
    end else begin
      if (bus.imem_req && gnt) begin
        q.push_back(bus.imem_addr);
        n_acc <= n_acc + 1;
      end
      m_rvalid <= rsp_en && q.size() != 0;
      if (rsp_en && q.size() != 0) m_rdata <= word(q.pop_front());
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic do_reset;
    rstn = 0; gnt = 0; ready = 0; redirect = 0; rsp_en = 1; inj = 0; redirect_pc = 0;
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    rstn = 1;
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin @(negedge clk); n++; end
    chk(tag, 32'(instr_valid), 1);
  endtask
  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.imem_req && n < 20) begin @(negedge clk); n++; end
    chk(tag, 32'(bus.imem_req), 1);
  endtask
  initial begin
    do_reset;
    #1;
    chk("first_req", 32'(bus.imem_req), 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    inj = 1;
    @(negedge clk);
    inj = 0;
    chk("stale_level", 32'(level), 0);
    chk("stale_valid", 32'(instr_valid), 0);
    gnt = 1; ready = 1;
    @(negedge clk);
    chk("s_addr1", bus.imem_addr, 32'h4);
    chk("s_valid0", 32'(instr_valid), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s_valid", 32'(instr_valid), 1);
      chk("s_pc", instr_pc, 32'(4 * i));
      chk("s_instr", instr, word(32'(4 * i)));
    end
    do_reset;
    gnt = 1; ready = 1;
    repeat (2) @(negedge clk);
    gnt = 0;
    repeat (3) begin
      chk("hold_addr", bus.imem_addr, 32'h8);
      chk("hold_req", 32'(bus.imem_req), 1);
      @(negedge clk);
    end
    chk("hold_addr_end", bus.imem_addr, 32'h8);
    gnt = 1;
    @(negedge clk);
    chk("hold_next", bus.imem_addr, 32'hC);
    do_reset;
    gnt = 1; ready = 0;
    repeat (10) @(negedge clk);
    chk("cr_acc4", 32'(n_acc), 4);
    chk("cr_level4", 32'(level), 4);
    chk("cr_req0", 32'(bus.imem_req), 0);
    chk("cr_pc_hold", instr_pc, 32'h0);
    chk("cr_instr_hold", instr, word(32'h0));
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk("cr_level3", 32'(level), 3);
    chk("cr_req1", 32'(bus.imem_req), 1);
    chk("cr_addr10", bus.imem_addr, 32'h10);
    chk("cr_pc4", instr_pc, 32'h4);
    @(negedge clk);
    chk("cr_acc5", 32'(n_acc), 5);
    chk("cr_req_again0", 32'(bus.imem_req), 0);
    do_reset;
    gnt = 1; ready = 1; rsp_en = 0;
    repeat (2) @(negedge clk);
    chk("rd_acc2", 32'(n_acc), 2);
    chk("rd_req_full", 32'(bus.imem_req), 0);
    redirect = 1; redirect_pc = 32'h103; rsp_en = 1;
    #1;
    chk("rd_req_redir", 32'(bus.imem_req), 0);
    @(negedge clk);
    redirect = 0;
    chk("rd_level0", 32'(level), 0);
    chk("rd_drain_req", 32'(bus.imem_req), 0);
    wait_req("rd_req_back");
    chk("rd_addr", bus.imem_addr, 32'h100);
    chk("rd_level_still0", 32'(level), 0);
    wait_valid("rd_valid");
    chk("rd_pc", instr_pc, 32'h100);
    chk("rd_instr", instr, word(32'h100));
    do_reset;
    redirect = 1; redirect_pc = 32'h200;
    #1;
    chk("r0_req_low", 32'(bus.imem_req), 0);
    @(negedge clk);
    redirect = 0;
    #1;
    chk("r0_req_high", 32'(bus.imem_req), 1);
    chk("r0_addr", bus.imem_addr, 32'h200);
    gnt = 1;
    wait_valid("rp_valid");
    ready = 1; redirect = 1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 0; ready = 0;
    chk("rp_level0", 32'(level), 0);
    chk("rp_valid0", 32'(instr_valid), 0);
    wait_valid("rp_valid2");
    chk("rp_pc", instr_pc, 32'h300);
    chk("rp_instr", instr, word(32'h300));
    do_reset;
    exp_pc = 0;
    for (int c = 0; c < 600; c++) begin
      gnt = $urandom_range(0, 3) != 0;
      ready = $urandom_range(0, 2) != 0;
      rsp_en = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 19) == 0;
      redirect_pc = $urandom;
      #1;
      if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (instr_valid && ready) begin
        chk("rnd_pc", instr_pc, exp_pc);
        chk("rnd_instr", instr, word(exp_pc));
        exp_pc += 32'd4;
        pops++;
      end
      chk("rnd_level", 32'(level <= 3'd4), 1);
      @(negedge clk);
    end
    chk("rnd_pops", 32'(pops > 50), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
